// File: rtl/layered_color_mapper.sv
// rtl/layered_color_mapper.sv - priority sprite-layer resolver, CPU palette and flash, 2-cycle pixel pipe
module layered_color_mapper #(
  parameter int NUM_LAYERS   = 4,
  parameter int IDX_W        = 4,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [NUM_LAYERS-1:0]       layer_flash_en,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [23:0]                 pal_data,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_valid
);

  localparam int CNT_W     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PAL_DEPTH = 2 ** IDX_W;

  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic             flash_phase_q, flash_phase_d;

  logic             hit_q, hit_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [6:0]       x_q;
  logic             valid1_q;

  logic [23:0]      rgb_q, rgb_d;
  logic             valid2_q;

  logic [23:0]      pal_q [PAL_DEPTH];

  // DrawY and the sub-tile X bits carry no information for the colour decision.
  logic unused_inputs;
  assign unused_inputs = ^{DrawY, DrawX[2:0]};

  always_comb begin
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;
    if (frame_start) begin
      if (flash_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
        flash_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end
  end

  // Walk from lowest to highest priority so layer 0 overwrites last.
  always_comb begin
    hit_d     = 1'b0;
    win_idx_d = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if ((layer_idx[k*IDX_W +: IDX_W] != '0) && !(layer_flash_en[k] && flash_phase_q)) begin
        hit_d     = 1'b1;
        win_idx_d = layer_idx[k*IDX_W +: IDX_W];
      end
    end
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (valid1_q) begin
      if (hit_q) begin
        rgb_d = pal_q[win_idx_q];
      end else begin
        rgb_d = {8'h3F, 8'h00, 8'h7F - {1'b0, x_q}};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
      hit_q         <= 1'b0;
      win_idx_q     <= '0;
      x_q           <= '0;
      valid1_q      <= 1'b0;
      rgb_q         <= 24'h000000;
      valid2_q      <= 1'b0;
    end else begin
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
      hit_q         <= hit_d;
      win_idx_q     <= win_idx_d;
      x_q           <= DrawX[9:3];
      valid1_q      <= pix_valid;
      rgb_q         <= rgb_d;
      valid2_q      <= valid1_q;
    end
  end

  // Stage 2 samples pal_q at the same edge the write lands: read-before-write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_q[i] <= 24'h000000;
      end
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  assign VGA_R     = rgb_q[23:16];
  assign VGA_G     = rgb_q[15:8];
  assign VGA_B     = rgb_q[7:0];
  assign out_valid = valid2_q;

endmodule

// File: tb/tb_layered_color_mapper.sv
// tb/tb_layered_color_mapper.sv - directed self-checking bench for layered_color_mapper
module tb_layered_color_mapper;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [15:0] layer_idx;
  logic [3:0]  layer_flash_en;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  layered_color_mapper #(.NUM_LAYERS(4), .IDX_W(4), .FLASH_FRAMES(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .layer_idx(layer_idx), .layer_flash_en(layer_flash_en),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_addr = a; pal_data = d;
    tick();
    pal_we = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; frame_start = 0; pix_valid = 0; DrawX = 0; DrawY = 0;
    layer_idx = 0; layer_flash_en = 0; pal_we = 0; pal_addr = 0; pal_data = 0;
    tick(); tick();
    Reset_n = 1'b1;
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B, out_valid} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rgb=%h valid=%b, expected rgb=000000 valid=0", {VGA_R, VGA_G, VGA_B}, out_valid);
    end
  endtask

  task automatic test_background();
    logic [9:0]  xs  [3] = '{10'd0, 10'd1016, 10'd256};
    logic [23:0] exp [3] = '{24'h3F007F, 24'h3F0000, 24'h3F005F};
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1; layer_idx = 0; DrawX = xs[i]; DrawY = 10'd100;
      tick(); tick();
      n_checks++;
      if ({VGA_R, VGA_G, VGA_B} !== exp[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL background_%0d: got rgb=%h valid=%b, expected rgb=%h valid=1", i, {VGA_R, VGA_G, VGA_B}, out_valid, exp[i]);
      end
    end
    pix_valid = 0;
    tick(); tick();
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_invalid: got rgb=%h valid=%b, expected rgb=000000 valid=0", {VGA_R, VGA_G, VGA_B}, out_valid);
    end
  endtask

  task automatic test_priority();
    pal_write(4'd5, 24'hFFFFFF);
    pal_write(4'd2, 24'h00FF00);
    pix_valid = 1; DrawX = 10'd40; layer_idx = 16'h2050;
    tick(); tick();
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL priority_l1: got rgb=%h valid=%b, expected rgb=FFFFFF valid=1", {VGA_R, VGA_G, VGA_B}, out_valid);
    end
    layer_idx = 16'h2000;
    tick(); tick();
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h00FF00) begin
      n_fail++;
      $display("FAIL priority_l3: got rgb=%h, expected rgb=00FF00", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_flash();
    logic [23:0] exp;
    pix_valid = 1; DrawX = 10'd8; layer_idx = 16'h0205; layer_flash_en = 4'b0001;
    for (int f = 0; f <= 16; f++) begin
      tick(); tick();
      exp = ((f / 8) % 2 == 0) ? 24'hFFFFFF : 24'h00FF00;
      n_checks++;
      if ({VGA_R, VGA_G, VGA_B} !== exp) begin
        n_fail++;
        $display("FAIL flash_frame_%0d: got rgb=%h, expected rgb=%h", f, {VGA_R, VGA_G, VGA_B}, exp);
      end
      if (f < 16) frame_pulse();
    end
    layer_flash_en = 0;
  endtask

  task automatic test_read_before_write();
    pix_valid = 1; layer_idx = 16'h0050;
    tick();
    pal_we = 1; pal_addr = 4'd5; pal_data = 24'h123456;
    tick();
    pal_we = 0;
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL rbw_old: got rgb=%h, expected rgb=FFFFFF", {VGA_R, VGA_G, VGA_B});
    end
    tick();
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) begin
      n_fail++;
      $display("FAIL rbw_new: got rgb=%h, expected rgb=123456", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_valid_toggle();
    logic [24:0] exp [3] = '{{24'h123456, 1'b1}, {24'h000000, 1'b0}, {24'h123456, 1'b1}};
    logic [24:0] got [3];
    layer_idx = 16'h0050;
    pix_valid = 1; tick();
    pix_valid = 0; tick(); got[0] = {VGA_R, VGA_G, VGA_B, out_valid};
    pix_valid = 1; tick(); got[1] = {VGA_R, VGA_G, VGA_B, out_valid};
    tick();               got[2] = {VGA_R, VGA_G, VGA_B, out_valid};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL valid_toggle_%0d: got rgb/valid=%h, expected %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    layer_idx = 16'h0050; layer_flash_en = 4'b0010; pix_valid = 1;
    for (int i = 0; i < 8; i++) frame_pulse();
    tick(); tick();
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h3F007E) begin
      n_fail++;
      $display("FAIL phase1_before_reset: got rgb=%h, expected rgb=3F007E", {VGA_R, VGA_G, VGA_B});
    end
    layer_flash_en = 0;
    tick(); tick();
    #1 Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got rgb=%h valid=%b, expected rgb=000000 valid=0", {VGA_R, VGA_G, VGA_B}, out_valid);
    end
    tick();
    Reset_n = 1'b1;
    layer_flash_en = 4'b0010;
    tick(); tick();
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_pal_phase: got rgb=%h valid=%b, expected rgb=000000 valid=1", {VGA_R, VGA_G, VGA_B}, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_background();
    test_priority();
    test_flash();
    test_read_before_write();
    test_valid_toggle();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layered_color_mapper.md
Name: layered_color_mapper

Overview:
Pipelined, parametrised successor to the single-sprite colour mapper. It resolves NUM_LAYERS sprite layers (duck, dead duck, dog, cursor, ...) by fixed priority. Each layer supplies a palette index, and index 0 is transparent. The winning index is looked up in a CPU-writable palette; with no opaque hit, the block outputs the purple-gradient background. Per-layer, frame-counted flashing is supported for effects such as the dead duck. It sits between the sprite hit-detection logic and the VGA DAC pins.

Parameters:
NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority
IDX_W, 4, palette index width; palette has 2**IDX_W entries of 24 bits
FLASH_FRAMES, 8, frames per flash half-period (must be >= 1)

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse at start of each frame (vsync edge)
pix_valid  in  1  DrawX/DrawY inside the active region this cycle
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
layer_idx  in  NUM_LAYERS*IDX_W  packed per-layer palette index; layer k uses bits [k*IDX_W +: IDX_W]; 0 = transparent
layer_flash_en  in  NUM_LAYERS  layer k blinks when set
pal_we  in  1  palette write strobe
pal_addr  in  IDX_W  palette write address
pal_data  in  24  palette write data {R,G,B}
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
out_valid  out  1  pix_valid delayed to align with the RGB outputs

Behaviour:
- Reset (async, Reset_n=0): all pipeline registers, VGA_R/G/B=0, out_valid=0, flash counter=0, flash_phase=0, all palette entries=24'h000000.
- Latency is exactly 2 Clk cycles from pix_valid/DrawX/layer_idx to VGA_*/out_valid. Throughput is 1 pixel/cycle with no stalls.
- Stage 1 (registered):
  - Layer k is opaque iff layer_idx[k] != 0 and !(layer_flash_en[k] && flash_phase).
  - The winner is the lowest-numbered opaque layer.
  - Registered outputs: hit (any opaque layer), win_idx, DrawX[9:3], pix_valid.
- Stage 2 (registered):
  - If !valid: RGB = 0 (blanking).
  - Else if hit: RGB = palette[win_idx].
  - Else: R = 8'h3F, G = 8'h00, B = 8'h7F - {1'b0, DrawX[9:3]}. The subtraction is 8-bit modulo 256; for example, DrawX[9:3]=127 gives B = 8'h00, and DrawX[9:3]=0x7F+1 cannot occur.
- Palette:
  - Register array, synchronous write on the pal_we rising-clock cycle.
  - The stage-2 read is read-before-write: a write to the entry being read in the same cycle shows the old value, and the new value appears from the next pixel on.
- Flash:
  - The counter increments on each frame_start.
  - When the counter reaches FLASH_FRAMES-1 together with a frame_start, it wraps to 0 and flash_phase toggles.
  - Phase 0 = visible, phase 1 = flashing layers transparent.
  - A frame_start pulse on the same cycle as pixel data affects only stage-1 evaluation from the next cycle on.
- Simultaneous pal_we and frame_start are independent; both take effect.
- Reset mid-frame: outputs go to 0 immediately (async). After release, the first valid output appears 2 cycles after the first sampled pix_valid.
- No X-propagation requirement beyond the above: layer_idx is ignored when pix_valid=0, but the pipeline still advances.

Test Plan:
- Reset, then pix_valid=1, all layer_idx=0, DrawX=0 -> after 2 cycles RGB=3F/00/7F, out_valid=1; DrawX=1016 (>>3 = 127) -> B=00.
- Write palette[5]=24'hFFFFFF and palette[2]=24'h00FF00; set layer1 idx=5, layer3 idx=2 -> RGB=FFFFFF (layer 1 wins); set layer1 idx=0 -> RGB=00FF00.
- Set layer0 idx=5, layer_flash_en[0]=1, layer2 idx=2, FLASH_FRAMES=8 -> FFFFFF for frames 0-7, 00FF00 for frames 8-15, FFFFFF again at frame 16.
- Drive pal_we to palette[5]=24'h123456 on the same cycle stage 2 reads entry 5 -> that pixel outputs the old FFFFFF, and the next pixel outputs 123456.
- Toggle pix_valid 1,0,1 with opaque hits -> RGB is 0 and out_valid=0 exactly on the middle output cycle, 2 cycles later.
- Assert Reset_n=0 asynchronously mid-line with RGB nonzero -> RGB=0 and out_valid=0 without a clock edge; palette reads back 0; flash_phase=0.
